// File: rtl/comb_decim.sv
// rtl/comb_decim.sv - CIC decimator comb section: decimation counter plus N_STAGES pipelined comb stages.
// Define COMB_DECIM_ROUND_EN to round instead of truncate when O_WIDTH < I_WIDTH.
module comb_decim #(
    parameter int I_WIDTH  = 9,
    parameter int O_WIDTH  = 9,
    parameter int R        = 16,
    parameter int N_STAGES = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [I_WIDTH-1:0] i_x,
    output logic [O_WIDTH-1:0] o_y,
    output logic               o_valid
);

    localparam int CW = (R > 2) ? $clog2(R) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

    if (R < 2 || R < N_STAGES + 1) begin : g_bad_r
        $error("comb_decim: R must be >= 2 and >= N_STAGES+1");
    end
    if (N_STAGES < 1 || N_STAGES > 8) begin : g_bad_n
        $error("comb_decim: N_STAGES must be in 1..8");
    end
    if (O_WIDTH < 1 || O_WIDTH > I_WIDTH) begin : g_bad_o
        $error("comb_decim: O_WIDTH must be in 1..I_WIDTH");
    end

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_STAGES:0]   stb_q, stb_d;
    logic [I_WIDTH-1:0]  stage_q [0:N_STAGES];
    logic [I_WIDTH-1:0]  stage_d [0:N_STAGES];
    logic [I_WIDTH-1:0]  prev_q  [1:N_STAGES];
    logic [I_WIDTH-1:0]  prev_d  [1:N_STAGES];
    logic                dec_evt;

    // stage_q[0] holds the captured sample; stb_q[k-1] marks the cycle stage k updates.
    always_comb begin
        dec_evt = i_en && (cnt_q == CNT_LAST);
        cnt_d   = cnt_q;
        if (i_en) begin
            cnt_d = dec_evt ? '0 : cnt_q + CW'(1);
        end
        stb_d   = {stb_q[N_STAGES-1:0], dec_evt};
        stage_d = stage_q;
        prev_d  = prev_q;
        if (dec_evt) begin
            stage_d[0] = i_x;
        end
        for (int k = 1; k <= N_STAGES; k++) begin
            if (stb_q[k-1]) begin
                stage_d[k] = stage_q[k-1] - prev_q[k];
                prev_d[k]  = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            stb_q <= '0;
            for (int k = 0; k <= N_STAGES; k++) begin
                stage_q[k] <= '0;
            end
            for (int k = 1; k <= N_STAGES; k++) begin
                prev_q[k] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            stb_q <= stb_d;
            for (int k = 0; k <= N_STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
            for (int k = 1; k <= N_STAGES; k++) begin
                prev_q[k] <= prev_d[k];
            end
        end
    end

    assign o_valid = stb_q[N_STAGES];

`ifdef COMB_DECIM_ROUND_EN
    if (O_WIDTH < I_WIDTH) begin : g_round
        localparam logic [I_WIDTH-1:0] HALF = I_WIDTH'(1) << (I_WIDTH - O_WIDTH - 1);
        logic [I_WIDTH-1:0] rnd;
        assign rnd = stage_q[N_STAGES] + HALF;
        assign o_y = rnd[I_WIDTH-1 -: O_WIDTH];
    end else begin : g_trunc
        assign o_y = stage_q[N_STAGES][I_WIDTH-1 -: O_WIDTH];
    end
`else
    assign o_y = stage_q[N_STAGES][I_WIDTH-1 -: O_WIDTH];
`endif

endmodule

// File: doc/comb_decim.md
COMB_DECIM -- requirements
Module: comb_decim

Interface
REQ-001 Parameter I_WIDTH, default 9, input sample width; matches integrator output width.
REQ-002 Parameter O_WIDTH, default 9, output width; legal range 1..I_WIDTH.
REQ-003 Parameter R, default 16, decimation ratio; legal range R >= N_STAGES+1 and R >= 2; elaboration SHALL fail otherwise.
REQ-004 Parameter N_STAGES, default 3, number of cascaded comb stages (differential delay 1); legal range 1..8.
REQ-005 i_clk  in  1  single clock; all state updates on rising edge.
REQ-006 i_rst_n  in  1  reset; synchronous, active-low.
REQ-007 i_en  in  1  input sample qualifier; i_x consumed only on cycles with i_en=1.
REQ-008 i_x  in  I_WIDTH  two's-complement integrator output.
REQ-009 o_y  out  O_WIDTH  decimated comb output, two's-complement.
REQ-010 o_valid  out  1  one-cycle strobe, o_y updated this cycle.

Function
REQ-011 Decimation counter SHALL count enabled cycles 0..R-1 and wrap to 0; it holds its value while i_en=0.
REQ-012 Decimation event SHALL occur on a cycle with i_en=1 and counter=R-1; i_x is captured as stage-0 input on that cycle.
REQ-013 Comb stage k (1..N_STAGES) SHALL compute d_k = x_k - x_k_prev, where x_k_prev is that stage's input at the previous decimation event; x_k_prev is updated only on that stage's own update.
REQ-014 Stage k SHALL be registered and update exactly k cycles after the decimation event; strobe pipeline advances every clock regardless of i_en.
REQ-015 o_valid SHALL assert for exactly one cycle, N_STAGES cycles after the decimation event; o_y updates on that same cycle and holds otherwise.
REQ-016 All internal arithmetic SHALL be I_WIDTH bits, modulo 2^I_WIDTH (wrap, no saturation), so CIC overflow cancels correctly.
REQ-017 o_y SHALL be bits [I_WIDTH-1 : I_WIDTH-O_WIDTH] of last-stage result, subject to REQ-022.
REQ-018 Since R > N_STAGES, pipelined events SHALL never overlap; no back-pressure exists.
REQ-019 First N_STAGES outputs after reset are startup transients (prev registers start at 0) and SHALL be emitted with o_valid, not suppressed.

Reset
REQ-020 While i_rst_n=0 at a clock edge: counter, all stage and prev registers, strobe pipeline, o_y SHALL become 0, o_valid SHALL be 0.
REQ-021 Reset mid-operation SHALL discard in-flight strobes; first decimation event after release occurs on the R-th enabled cycle.

Configuration
REQ-022 Macro COMB_DECIM_ROUND_EN defined: o_y = upper O_WIDTH bits of (result + 2^(I_WIDTH-O_WIDTH-1)), modulo 2^I_WIDTH, when O_WIDTH < I_WIDTH; undefined: plain truncation per REQ-017. With O_WIDTH = I_WIDTH both builds SHALL be identical.

Verification
REQ-023 Defaults except R=4, N_STAGES=1; i_en=1, i_x ramp 0,1,2,... from reset release -> o_valid every 4 cycles, o_y = 3 first, then 4 steadily.
REQ-024 R=4, N_STAGES=1; i_x constant 5 -> first o_y=5, all later o_y=0.
REQ-025 R=2, N_STAGES=1; i_x = 100*k mod 512 each cycle -> o_y = 200 on every strobe after the first, including across wrap (400 -> 88).
REQ-026 R=4; i_en toggles 1,0 every cycle -> o_valid period 8 cycles, output values identical to REQ-023 sample-wise.
REQ-027 Defaults, R=4; assert i_rst_n=0 for one cycle two cycles after a decimation event -> no o_valid for that event; next strobe 4 enabled cycles + N_STAGES after release.
REQ-028 I_WIDTH=9, O_WIDTH=8, N_STAGES=1, result 3 -> o_y=1 without COMB_DECIM_ROUND_EN, o_y=2 with it.
